// File: rtl/i2c_master_seq.sv
// Register-bus sequencer for i2c_master_regs: turns one host request into a full I2C register access.
// Define I2C_SEQ_POLL_EN to detect byte completion by polling SR.TIP instead of using Int.

`ifndef I2C_PRER
`define I2C_PRER 0
`endif
`ifndef I2C_CTR
`define I2C_CTR 2
`endif
`ifndef I2C_TXR
`define I2C_TXR 3
`endif
`ifndef I2C_RXR
`define I2C_RXR 3
`endif
`ifndef I2C_CR
`define I2C_CR 4
`endif
`ifndef I2C_SR
`define I2C_SR 4
`endif

// state     | meaning
// INIT_PRE  | write PRESCALE to PRER
// INIT_EN   | write 8'h80 to CTR (core enable)
// IDLE      | Ready=1, accept Req
// LD_TX     | write current byte to TXR
// LD_CR     | write current command to CR, arm timeout
// WAIT      | wait for byte/stop completion or timeout
// RD_SR     | Addr=SR, first read cycle
// CHK       | sample SR, write IACK, pick next step
// RD_RX     | read RXR into Rdata
// ABORT_STO | write STO to CR, then wait in WAIT
// FIN       | Done pulse, back to IDLE
module i2c_master_seq #(
   parameter int          DWIDTH   = 8,
   parameter int          AWIDTH   = 3,
   parameter logic [7:0]  PRESCALE = 8'd49,
   parameter logic [15:0] TIMEOUT  = 16'hFFFF
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Req,
   input  logic              Rw,
   input  logic [6:0]        Slv_addr,
   input  logic [7:0]        Reg_addr,
   input  logic [7:0]        Wdata,
   output logic              Ready,
   output logic              Done,
   output logic [1:0]        Err,
   output logic [7:0]        Rdata,
   output logic [AWIDTH-1:0] Addr,
   output logic [DWIDTH-1:0] Dout,
   input  logic [DWIDTH-1:0] Din,
   output logic              Wr,
   input  logic              Int
);

   localparam logic [AWIDTH-1:0] A_PRER = AWIDTH'(`I2C_PRER);
   localparam logic [AWIDTH-1:0] A_CTR  = AWIDTH'(`I2C_CTR);
   localparam logic [AWIDTH-1:0] A_TXR  = AWIDTH'(`I2C_TXR);
   localparam logic [AWIDTH-1:0] A_RXR  = AWIDTH'(`I2C_RXR);
   localparam logic [AWIDTH-1:0] A_CR   = AWIDTH'(`I2C_CR);
   localparam logic [AWIDTH-1:0] A_SR   = AWIDTH'(`I2C_SR);

   localparam logic [7:0] CMD_STA  = 8'h80;
   localparam logic [7:0] CMD_STO  = 8'h40;
   localparam logic [7:0] CMD_RD   = 8'h20;
   localparam logic [7:0] CMD_WR   = 8'h10;
   localparam logic [7:0] CMD_ACK  = 8'h08;
   localparam logic [7:0] CMD_IACK = 8'h01;

   typedef enum logic [3:0] {
      S_INIT_PRE, S_INIT_EN, S_IDLE, S_LD_TX, S_LD_CR, S_WAIT,
      S_RD_SR, S_CHK, S_RD_RX, S_ABORT_STO, S_FIN
   } state_t;

   state_t      state;
   logic [1:0]  idx;
   logic [1:0]  ph;
   logic [15:0] tmo;
   logic        abort_q;
   logic        rw_q;
   logic [6:0]  slv_q;
   logic [7:0]  reg_q;
   logic [7:0]  wdata_q;
   logic [7:0]  tx_byte;
   logic [7:0]  cmd_byte;
   logic        bus_done;

`ifdef I2C_SEQ_POLL_EN
   // SR has been on Addr for two cycles when ph reaches 2
   logic unused_int;
   assign unused_int = Int;
   assign bus_done   = (ph == 2'd2) && !Din[1];
`else
   assign bus_done = Int;
`endif

   always_comb begin
      tx_byte  = {slv_q, 1'b0};
      cmd_byte = CMD_STA | CMD_WR;
      case (idx)
         2'd1: begin
            tx_byte  = reg_q;
            cmd_byte = CMD_WR;
         end
         2'd2: begin
            tx_byte  = rw_q ? {slv_q, 1'b1} : wdata_q;
            cmd_byte = rw_q ? (CMD_STA | CMD_WR) : (CMD_WR | CMD_STO);
         end
         2'd3: begin
            tx_byte  = 8'h00;
            cmd_byte = CMD_RD | CMD_ACK | CMD_STO;
         end
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state   <= S_INIT_PRE;
         idx     <= 2'd0;
         ph      <= 2'd0;
         tmo     <= 16'd0;
         abort_q <= 1'b0;
         rw_q    <= 1'b0;
         slv_q   <= 7'd0;
         reg_q   <= 8'd0;
         wdata_q <= 8'd0;
         Ready   <= 1'b0;
         Done    <= 1'b0;
         Err     <= 2'd0;
         Rdata   <= 8'd0;
         Addr    <= '0;
         Dout    <= '0;
         Wr      <= 1'b0;
      end else begin
         Wr   <= 1'b0;
         Done <= 1'b0;
         case (state)
            S_INIT_PRE: begin
               Wr    <= 1'b1;
               Addr  <= A_PRER;
               Dout  <= DWIDTH'(PRESCALE);
               state <= S_INIT_EN;
            end
            S_INIT_EN: begin
               Wr    <= 1'b1;
               Addr  <= A_CTR;
               Dout  <= DWIDTH'(8'h80);
               state <= S_IDLE;
            end
            S_IDLE: begin
               Ready <= 1'b1;
               if (Ready && Req) begin
                  // first TXR load goes out in the cycle right after acceptance
                  Ready   <= 1'b0;
                  rw_q    <= Rw;
                  slv_q   <= Slv_addr;
                  reg_q   <= Reg_addr;
                  wdata_q <= Wdata;
                  idx     <= 2'd0;
                  Err     <= 2'd0;
                  abort_q <= 1'b0;
                  Wr      <= 1'b1;
                  Addr    <= A_TXR;
                  Dout    <= DWIDTH'({Slv_addr, 1'b0});
                  state   <= S_LD_CR;
               end
            end
            S_LD_TX: begin
               Wr    <= 1'b1;
               Addr  <= A_TXR;
               Dout  <= DWIDTH'(tx_byte);
               state <= S_LD_CR;
            end
            S_LD_CR: begin
               Wr    <= 1'b1;
               Addr  <= A_CR;
               Dout  <= DWIDTH'(cmd_byte);
               tmo   <= TIMEOUT - 16'd1;
               ph    <= 2'd0;
               state <= S_WAIT;
            end
            S_WAIT: begin
               if (bus_done) begin
                  if (abort_q) begin
                     // clear IF left by the STOP so the next request starts clean
                     Wr    <= 1'b1;
                     Addr  <= A_CR;
                     Dout  <= DWIDTH'(CMD_IACK);
                     state <= S_FIN;
                  end else begin
                     Addr  <= A_SR;
                     state <= S_RD_SR;
                  end
               end else if (tmo == 16'd0) begin
                  if (abort_q) begin
                     state <= S_FIN;
                  end else begin
                     Err     <= 2'd3;
                     abort_q <= 1'b1;
                     state   <= S_ABORT_STO;
                  end
               end else begin
                  tmo <= tmo - 16'd1;
                  ph  <= (ph == 2'd2) ? 2'd0 : ph + 2'd1;
`ifdef I2C_SEQ_POLL_EN
                  Addr <= A_SR;
`endif
               end
            end
            S_RD_SR: state <= S_CHK;
            S_CHK: begin
               Wr   <= 1'b1;
               Addr <= A_CR;
               Dout <= DWIDTH'(CMD_IACK);
               if (Din[5]) begin
                  // lost arbitration: the bus is not ours, so no STOP
                  Err   <= 2'd2;
                  state <= S_FIN;
               end else if (Din[7] && idx != 2'd3) begin
                  Err     <= 2'd1;
                  abort_q <= 1'b1;
                  state   <= S_ABORT_STO;
               end else if (idx == 2'd3) begin
                  ph    <= 2'd0;
                  state <= S_RD_RX;
               end else if (idx == 2'd2 && !rw_q) begin
                  state <= S_FIN;
               end else begin
                  idx   <= idx + 2'd1;
                  state <= (idx == 2'd2) ? S_LD_CR : S_LD_TX;
               end
            end
            S_RD_RX: begin
               case (ph)
                  2'd0: begin
                     Addr <= A_RXR;
                     ph   <= 2'd1;
                  end
                  2'd1: ph <= 2'd2;
                  default: begin
                     Rdata <= Din[7:0];
                     ph    <= 2'd0;
                     state <= S_FIN;
                  end
               endcase
            end
            S_ABORT_STO: begin
               Wr    <= 1'b1;
               Addr  <= A_CR;
               Dout  <= DWIDTH'(CMD_STO);
               tmo   <= TIMEOUT - 16'd1;
               ph    <= 2'd0;
               state <= S_WAIT;
            end
            S_FIN: begin
               Done  <= 1'b1;
               state <= S_IDLE;
            end
            default: state <= S_INIT_PRE;
         endcase
      end
   end

endmodule

// File: tb/tb_i2c_master_seq.sv
// Bench for i2c_master_seq: behavioural i2c_master_regs model plus a scoreboard of expected bus writes.
`timescale 1ns/1ps
module tb_i2c_master_seq;

   localparam logic [2:0] A_PRER = 3'd0;
   localparam logic [2:0] A_CTR  = 3'd2;
   localparam logic [2:0] A_TXR  = 3'd3;
   localparam logic [2:0] A_RXR  = 3'd3;
   localparam logic [2:0] A_CR   = 3'd4;
   localparam logic [2:0] A_SR   = 3'd4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req = 1'b0;
   logic       rw = 1'b0;
   logic [6:0] slv = 7'd0;
   logic [7:0] regad = 8'd0;
   logic [7:0] wdata = 8'd0;
   logic       ready, done, wr, irq;
   logic [1:0] err;
   logic [7:0] rdata, dout, din;
   logic [2:0] addr;

   always #5 clk = ~clk;

   i2c_master_seq #(.TIMEOUT(16'd20)) dut (
      .Clk(clk), .Rst_n(rst_n), .Req(req), .Rw(rw), .Slv_addr(slv),
      .Reg_addr(regad), .Wdata(wdata), .Ready(ready), .Done(done),
      .Err(err), .Rdata(rdata), .Addr(addr), .Dout(dout), .Din(din),
      .Wr(wr), .Int(irq)
   );

   // regs model: a CR command sets TIP, completes after lat cycles with IF set
   int   lat = 4;
   bit   quiet = 1'b0;
   int   nack_at = -1;
   int   al_at = -1;
   logic tip, iflag, rxack, al;
   int   cnt, cmd_n;

   always @(posedge clk) begin
      if (!rst_n) begin
         tip <= 1'b0; iflag <= 1'b0; rxack <= 1'b0; al <= 1'b0; cnt <= 0; cmd_n <= 0;
      end else begin
         if (ready) cmd_n <= 0;
         if (tip && !quiet) begin
            if (cnt <= 1) begin
               tip   <= 1'b0;
               iflag <= 1'b1;
               rxack <= (cmd_n == nack_at);
               al    <= (cmd_n == al_at);
               cmd_n <= cmd_n + 1;
            end else cnt <= cnt - 1;
         end
         if (wr && addr == A_CR) begin
            if (dout[0]) iflag <= 1'b0;
            if (dout[7:4] != 4'd0) begin
               tip <= 1'b1; cnt <= lat; rxack <= 1'b0; al <= 1'b0;
            end
         end
      end
   end

   assign irq = iflag;
   always_comb begin
      din = 8'h00;
      case (addr)
         A_SR:  din = {rxack, 1'b0, al, 3'b000, tip, iflag};
         A_RXR: din = 8'h3C;
         default: din = 8'h00;
      endcase
   end

   typedef struct packed {logic [2:0] a; logic [7:0] d;} wr_t;
   wr_t exp_q[$];
   wr_t e;
   int  checks = 0;
   int  failures = 0;
   int  cyc = 0;
   int  t_cmd = 0;
   int  t_sto = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push(input logic [2:0] a, input logic [7:0] d);
      exp_q.push_back('{a: a, d: d});
   endtask

   // scoreboard: every non-IACK register write must match the next expected one
   always @(negedge clk) begin
      cyc++;
      if (wr && !(addr == A_CR && dout == 8'h01)) begin
         if (addr == A_CR && dout == 8'h40) t_sto = cyc;
         else if (addr == A_CR) t_cmd = cyc;
         checks++;
         assert (exp_q.size() > 0) else begin
            failures++;
            $error("FAIL extra_write observed=%h expected=none", {addr, dout});
         end
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("bus_write", {21'd0, addr, dout}, {21'd0, e.a, e.d});
         end
      end
   end

   task automatic issue(input logic r, input logic [6:0] s, input logic [7:0] ra, input logic [7:0] wd);
      for (int i = 0; i < 200 && !ready; i++) @(negedge clk);
      check("ready_before_req", ready, 1'b1);
      req = 1'b1; rw = r; slv = s; regad = ra; wdata = wd;
      @(negedge clk);
      req = 1'b0; rw = ~r; slv = 7'h7F; regad = 8'hEE; wdata = 8'h5A;
      check("ready_low_after_accept", ready, 1'b0);
   endtask

   task automatic wait_done(input string tag, input logic [1:0] exp_err,
                            input bit chk_rd, input logic [7:0] exp_rd);
      int n = 0;
      while (!done && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check({tag, "_done"}, done, 1'b1);
      check({tag, "_err"}, err, exp_err);
      if (chk_rd) check({tag, "_rdata"}, rdata, exp_rd);
      check({tag, "_writes_left"}, exp_q.size(), 0);
      check({tag, "_ready_at_done"}, ready, 1'b0);
      @(negedge clk);
      check({tag, "_done_one_cycle"}, done, 1'b0);
      check({tag, "_ready_after_done"}, ready, 1'b1);
      check({tag, "_err_held"}, err, exp_err);
      if (chk_rd) check({tag, "_rdata_held"}, rdata, exp_rd);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("rst_outputs", {ready, done, err, rdata, addr, dout, wr}, 0);

      push(A_PRER, 8'h31); push(A_CTR, 8'h80);
      rst_n = 1'b1;
      @(negedge clk); check("ready_c1", ready, 1'b0);
      @(negedge clk); check("ready_c2", ready, 1'b0);
      @(negedge clk); check("ready_c3", ready, 1'b1);
      check("init_writes_left", exp_q.size(), 0);

      // register write, all ACK
      push(A_TXR, 8'hA0); push(A_CR, 8'h90);
      push(A_TXR, 8'h10); push(A_CR, 8'h10);
      push(A_TXR, 8'hA5); push(A_CR, 8'h50);
      issue(1'b0, 7'h50, 8'h10, 8'hA5);
      wait_done("wr", 2'd0, 1'b0, 8'h00);

      // register read with repeated start; a stray Req mid-transaction is ignored
      push(A_TXR, 8'hA0); push(A_CR, 8'h90);
      push(A_TXR, 8'h22); push(A_CR, 8'h10);
      push(A_TXR, 8'hA1); push(A_CR, 8'h90);
      push(A_CR, 8'h68);
      issue(1'b1, 7'h50, 8'h22, 8'h00);
      repeat (4) @(negedge clk);
      req = 1'b1;
      @(negedge clk);
      req = 1'b0;
      wait_done("rd", 2'd0, 1'b1, 8'h3C);

      // NACK on the address byte -> STOP, Err=1
      nack_at = 0;
      push(A_TXR, 8'hA0); push(A_CR, 8'h90); push(A_CR, 8'h40);
      issue(1'b0, 7'h50, 8'h10, 8'h11);
      wait_done("nack", 2'd1, 1'b0, 8'h00);
      nack_at = -1;

      // arbitration lost on the second byte -> no STOP, Err=2
      al_at = 1;
      push(A_TXR, 8'hA0); push(A_CR, 8'h90);
      push(A_TXR, 8'h10); push(A_CR, 8'h10);
      issue(1'b0, 7'h50, 8'h10, 8'h11);
      wait_done("al", 2'd2, 1'b0, 8'h00);
      al_at = -1;

      // reset in the middle of a transaction -> re-initialise, no STOP
      push(A_TXR, 8'hA0); push(A_CR, 8'h90);
      issue(1'b0, 7'h50, 8'h10, 8'hA5);
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_wr", wr, 1'b0);
      check("midrst_ready", ready, 1'b0);
      check("midrst_writes_left", exp_q.size(), 0);
      push(A_PRER, 8'h31); push(A_CTR, 8'h80);
      rst_n = 1'b1;

      // read after re-initialisation
      push(A_TXR, 8'h54); push(A_CR, 8'h90);
      push(A_TXR, 8'h05); push(A_CR, 8'h10);
      push(A_TXR, 8'h55); push(A_CR, 8'h90);
      push(A_CR, 8'h68);
      issue(1'b1, 7'h2A, 8'h05, 8'h00);
      wait_done("rd2", 2'd0, 1'b1, 8'h3C);

`ifndef I2C_SEQ_POLL_EN
      // Int never arrives: timeout after 20 WAIT cycles, STOP, Err=3
      quiet = 1'b1;
      push(A_TXR, 8'hA0); push(A_CR, 8'h90); push(A_CR, 8'h40);
      issue(1'b0, 7'h50, 8'h10, 8'hA5);
      wait_done("tmo", 2'd3, 1'b0, 8'h00);
      check("tmo_gap", ((t_sto - t_cmd) >= 21) && ((t_sto - t_cmd) <= 22), 1'b1);
      quiet = 1'b0;
`else
      // polling: TIP clears 10 cycles after each command, within the 20-cycle timeout
      lat = 10;
      push(A_TXR, 8'hA0); push(A_CR, 8'h90);
      push(A_TXR, 8'h10); push(A_CR, 8'h10);
      push(A_TXR, 8'hA5); push(A_CR, 8'h50);
      issue(1'b0, 7'h50, 8'h10, 8'hA5);
      wait_done("poll", 2'd0, 1'b0, 8'h00);
      lat = 4;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/i2c_master_seq.md
# i2c_master_seq

Transaction sequencer that drives the system data bus of `i2c_master_regs` as its only bus master and turns one host request into a complete I2C register access.
- Supported accesses: single-byte register write, or single-byte register read with repeated start.
- After reset it programs the prescaler and enables the core.
- Per byte it loads TXR, issues a CR command, waits for completion, then checks SR for NACK and arbitration loss.
- It sits between a host-side controller and `i2c_master_regs`, replacing software-driven register access.

## Interface
Parameters:
- DWIDTH, 8, register bus data width
- AWIDTH, 3, register bus address width
- PRESCALE, 8'd49, value written to PRER at init
- TIMEOUT, 16'hFFFF, cycles allowed per byte before abort

Ports:
- Clk  in  1  system clock
- Rst_n  in  1  reset, synchronous, active-low
- Req  in  1  start transaction; sampled only while Ready=1
- Rw  in  1  0=register write, 1=register read
- Slv_addr  in  7  7-bit slave address
- Reg_addr  in  8  slave register index
- Wdata  in  8  data for register write
- Ready  out  1  idle and accepting Req
- Done  out  1  one-cycle pulse at end of transaction
- Err  out  2  valid with Done: 0 ok, 1 NACK, 2 arbitration lost, 3 timeout
- Rdata  out  8  read result, valid with Done when Rw=1 and Err=0
- Addr  out  AWIDTH  register address to `i2c_master_regs`
- Dout  out  DWIDTH  write data to DataIn
- Din  in  DWIDTH  DataOut from `i2c_master_regs`, combinational on Addr
- Wr  out  1  register write strobe, one cycle
- Int  in  1  interrupt request from `i2c_master_regs`

## Operation
- Register addresses use the `I2C_PRER`, `I2C_CTR`, `I2C_TXR`, `I2C_RXR`, `I2C_CR` and `I2C_SR` defines.
- CR bits: STA=7, STO=6, RD=5, WR=4, ACK=3, IACK=0.
- SR bits: RxACK=7, AL=5, TIP=1, IF=0.
- States:
  - INIT_PRE: write PRESCALE to PRER.
  - INIT_EN: write 8'h80 to CTR.
  - IDLE: Ready=1.
  - LD_TX: write the byte to TXR.
  - LD_CR: write the command to CR.
  - WAIT: wait for byte completion.
  - RD_SR: set Addr=SR.
  - CHK: sample Din, then write IACK to CR.
  - RD_RX: set Addr=RXR, sample Din into Rdata.
  - ABORT_STO: write STO to CR, then wait for completion.
  - FIN: Done pulse, return to IDLE.
- Byte list for a write (Rw=0):
  - {Slv_addr,0} with STA|WR
  - Reg_addr with WR
  - Wdata with WR|STO
- Byte list for a read (Rw=1):
  - {Slv_addr,0} with STA|WR
  - Reg_addr with WR
  - {Slv_addr,1} with STA|WR (repeated start)
  - no TXR load, RD|ACK|STO (master NACKs the last byte)
  - then RD_RX
- Byte index is a 2-bit counter, cleared on Req acceptance.
- CHK priority:
  - AL=1 -> Err=2 and FIN directly; no STOP, because the bus belongs to another master.
  - RxACK=1 on a write byte -> Err=1, then ABORT_STO.
  - Otherwise advance to the next byte.
  - RxACK is ignored on the RD byte.
- Request inputs are captured into internal registers on acceptance; later changes are ignored.
- Req while Ready=0 is ignored; there is no queueing.

## Timing
- Reset values: Ready=0, Done=0, Err=0, Rdata=0, Addr=0, Dout=0, Wr=0. State=INIT_PRE, byte counter=0, timeout counter=0.
- After reset, INIT_PRE and INIT_EN take one cycle each; Ready=1 on the 3rd cycle after Rst_n rises.
- Req sampled high with Ready=1 -> Ready=0 next cycle, and the LD_TX write is on the bus that cycle.
- Every register write holds Wr=1 for exactly one cycle, with Addr and Dout stable in that cycle.
- Every register read is two cycles: Addr is driven in cycle N and Din is sampled at the end of cycle N+1.
- WAIT exits on the first cycle with Int=1. The timeout counter restarts on WAIT entry; reaching TIMEOUT -> Err=3, then ABORT_STO.
- Done is high for exactly one cycle, with Err and Rdata stable from that cycle until the next Req acceptance. Ready rises the cycle after Done.
- Rst_n low mid-transaction: return to INIT_PRE next cycle with Wr=0. No STOP is issued; the core is re-initialised.
- Int already high on WAIT entry (stale IF) cannot occur, because CHK always clears it via IACK.

## Configuration
- Macro `I2C_SEQ_POLL_EN`.
- Defined: the Int input is ignored. WAIT alternates between Addr=SR and sampling Din, and exits when TIP=0, observed no earlier than 2 cycles after the CR write. The IACK write is still issued.
- Undefined: WAIT exits on Int as described under Timing.

## Test plan
- Reset, then a bus model of the regs:
  - required write sequence: PRER=8'h31, CTR=8'h80.
  - Ready=1 at cycle 3.
- Write transaction, Slv_addr=7'h50, Reg_addr=8'h10, Wdata=8'hA5, all ACK:
  - required TXR writes: 8'hA0, 8'h10, 8'hA5.
  - required CR writes: 8'h90, 8'h10, 8'h50.
  - Done with Err=0.
- Read transaction, Slv_addr=7'h50, Reg_addr=8'h22, RXR model returns 8'h3C:
  - required TXR writes: 8'hA0, 8'h22, 8'hA1.
  - required CR writes: 8'h90, 8'h10, 8'h90, 8'h68.
  - Rdata=8'h3C, Err=0.
- NACK on the address byte (SR=8'h81) -> CR write 8'h40 (STO), then Done with Err=1.
- AL on the second byte (SR=8'h21) -> no STO write, Done with Err=2.
- Int never asserted with TIMEOUT=16'd20 -> Err=3 after 20 WAIT cycles. Rerun with `I2C_SEQ_POLL_EN` defined and SR TIP cleared after 10 cycles -> Err=0.
